// File: rtl/adc128s_spi_model.sv
// SPI slave model of an 8-channel 12-bit ADC128S-style converter; result of the address sent in frame N returns in frame N+1.
// Optional: define ADC_MISO_TRISTATE_EN to float MISO while slave select is inactive.
module adc128s_spi_model #(
  parameter logic [2:0] LFT_CH   = 3'd0,
  parameter logic [2:0] RGHT_CH  = 3'd4,
  parameter logic [2:0] STEER_CH = 3'd5,
  parameter logic [2:0] BATT_CH  = 3'd6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  input  logic [11:0] ld_cell_lft,
  input  logic [11:0] ld_cell_rght,
  input  logic [11:0] steerPot,
  input  logic [11:0] batt
);

  localparam int unsigned DATA_W  = 12;
  localparam int unsigned FRAME_W = 16;
  localparam int unsigned CNT_W   = 5;

  logic               r_ss_ff1, r_ss_sync, r_ss_prev;
  logic               r_sclk_ff1, r_sclk_sync, r_sclk_prev;
  logic               r_mosi_ff1, r_mosi_sync;
  logic [FRAME_W-1:0] r_shift;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_over;
  logic [2:0]         r_chnl;

  logic               w_ss_fall, w_ss_rise, w_sclk_rise, w_full;
  logic [DATA_W-1:0]  w_value;

  // Bring the asynchronous SPI pins into the clk domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ss_ff1    <= 1'b1;
      r_ss_sync   <= 1'b1;
      r_ss_prev   <= 1'b1;
      r_sclk_ff1  <= 1'b0;
      r_sclk_sync <= 1'b0;
      r_sclk_prev <= 1'b0;
      r_mosi_ff1  <= 1'b0;
      r_mosi_sync <= 1'b0;
    end else begin
      r_ss_ff1    <= SS_n;
      r_ss_sync   <= r_ss_ff1;
      r_ss_prev   <= r_ss_sync;
      r_sclk_ff1  <= SCLK;
      r_sclk_sync <= r_sclk_ff1;
      r_sclk_prev <= r_sclk_sync;
      r_mosi_ff1  <= MOSI;
      r_mosi_sync <= r_mosi_ff1;
    end
  end

  assign w_ss_fall   = r_ss_prev & ~r_ss_sync;
  assign w_ss_rise   = ~r_ss_prev & r_ss_sync;
  assign w_sclk_rise = r_sclk_sync & ~r_sclk_prev;
  assign w_full      = (r_cnt == CNT_W'(FRAME_W)) & ~r_over;

  // Channel mux; unmapped addresses read as zero
  always_comb begin
    w_value = '0;
    case (r_chnl)
      LFT_CH:   w_value = ld_cell_lft;
      RGHT_CH:  w_value = ld_cell_rght;
      STEER_CH: w_value = steerPot;
      BATT_CH:  w_value = batt;
      default:  w_value = '0;
    endcase
  end

  // r_over flags a 17th rise so over-length frames do not update the channel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_over  <= 1'b0;
      r_chnl  <= 3'd0;
    end else if (w_ss_fall) begin
      r_shift <= {(FRAME_W-DATA_W)'(0), w_value};
      r_cnt   <= '0;
      r_over  <= 1'b0;
    end else if (!r_ss_sync && w_sclk_rise) begin
      r_shift <= {r_shift[FRAME_W-2:0], r_mosi_sync};
      if (r_cnt == CNT_W'(FRAME_W)) r_over <= 1'b1;
      else                          r_cnt  <= r_cnt + CNT_W'(1);
    end else if (w_ss_rise && w_full) begin
      r_chnl <= r_shift[13:11];
    end
  end

`ifdef ADC_MISO_TRISTATE_EN
  assign MISO = r_ss_sync ? 1'bz : r_shift[FRAME_W-1];
`else
  assign MISO = r_shift[FRAME_W-1];
`endif

endmodule

// File: tb/tb_adc128s_spi_model.sv
// Directed plus randomized bench for adc128s_spi_model against a channel-pipeline reference model.
module tb_adc128s_spi_model;

  logic        clk = 1'b0;
  logic        rst_n, SS_n, SCLK, MOSI, MISO;
  logic [11:0] ld_cell_lft, ld_cell_rght, steerPot, batt;

  int          checks = 0;
  int          errors = 0;
  logic [2:0]  chnl_model = 3'd0;

  always #5 clk = ~clk;

  adc128s_spi_model dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
    .ld_cell_lft(ld_cell_lft), .ld_cell_rght(ld_cell_rght),
    .steerPot(steerPot), .batt(batt)
  );

  function automatic logic [11:0] ref_value(input logic [2:0] ch);
    case (ch)
      3'd0:    return ld_cell_lft;
      3'd4:    return ld_cell_rght;
      3'd5:    return steerPot;
      3'd6:    return batt;
      default: return 12'h000;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Mode 0: master samples MISO just before raising SCLK
  task automatic xfer_bit(input logic b, output logic m);
    MOSI = b;
    tick(5);
    m = MISO;
    SCLK = 1'b1;
    tick(5);
    SCLK = 1'b0;
  endtask

  task automatic frame(input logic [15:0] tx, input int nbits, input logic mid_chg,
                       input logic [11:0] mid_batt, output logic [15:0] rx);
    logic m;
    logic b;
    SS_n = 1'b0;
    tick(6);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      b = (i < 16) ? tx[15-i] : 1'b0;
      if (mid_chg && i == 8) batt = mid_batt;
      xfer_bit(b, m);
      rx = {rx[14:0], m};
    end
    tick(2);
    SS_n = 1'b1;
    MOSI = 1'b0;
    tick(6);
  endtask

  // Full frames are checked; only full 16-bit frames advance the model channel
  task automatic run_frame(input string tag, input logic [15:0] tx, input int nbits,
                           input logic mid_chg, input logic [11:0] mid_batt);
    logic [15:0] exp;
    logic [15:0] rx;
    exp = {4'h0, ref_value(chnl_model)};
    frame(tx, nbits, mid_chg, mid_batt, rx);
    if (nbits == 16) begin
      check(tag, rx, exp);
      chnl_model = tx[13:11];
    end
  endtask

  task automatic check_idle(input string tag);
`ifdef ADC_MISO_TRISTATE_EN
    check(tag, {15'h0, MISO}, {15'h0, 1'bz});
`else
    check(tag, {15'h0, MISO}, 16'h0000);
`endif
  endtask

  initial begin
    logic        m;
    logic [31:0] rnd;
    rst_n = 1'b0; SS_n = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
    ld_cell_lft = 12'h300; ld_cell_rght = 12'h111; steerPot = 12'h222; batt = 12'h333;
    tick(3);
    check_idle("reset_miso");
    rst_n = 1'b1;
    tick(4);
    check_idle("idle_after_reset");

    run_frame("first_frame_lft", 16'h2000, 16, 1'b0, 12'h0);
    ld_cell_rght = 12'h300; steerPot = 12'h800;
    run_frame("pipelined_ch4", 16'h2800, 16, 1'b0, 12'h0);
    run_frame("steer_ch5", 16'h3000, 16, 1'b0, 12'h0);
    batt = 12'hFFF;
    run_frame("batt_full_scale", 16'h1800, 16, 1'b0, 12'h0);
    run_frame("unmapped_ch3", 16'h0000, 16, 1'b0, 12'h0);
`ifdef ADC_MISO_TRISTATE_EN
    check_idle("idle_between_frames");
`endif

    run_frame("set_ch4", 16'h2000, 16, 1'b0, 12'h0);
    run_frame("aborted_frame", 16'h3000, 8, 1'b0, 12'h0);
    run_frame("after_abort", 16'h2000, 16, 1'b0, 12'h0);
    run_frame("overlength_frame", 16'h3000, 17, 1'b0, 12'h0);
    run_frame("after_overlength", 16'h3000, 16, 1'b0, 12'h0);

    batt = 12'hA00;
    run_frame("midframe_batt_change", 16'h3000, 16, 1'b1, 12'h900);
    run_frame("batt_new_value", 16'h2800, 16, 1'b0, 12'h0);

    // Reset partway through a frame that addresses ch6
    SS_n = 1'b0;
    tick(6);
    for (int i = 0; i < 6; i++) xfer_bit((i == 2 || i == 3) ? 1'b1 : 1'b0, m);
    rst_n = 1'b0;
    tick(2);
    check_idle("midframe_reset_miso");
    SS_n = 1'b1;
    rst_n = 1'b1;
    chnl_model = 3'd0;
    tick(6);
    run_frame("after_midframe_reset", 16'h3000, 16, 1'b0, 12'h0);

    for (int k = 0; k < 20; k++) begin
      rnd = $urandom();
      ld_cell_lft  = 12'($urandom());
      ld_cell_rght = 12'($urandom());
      steerPot     = 12'($urandom());
      batt         = 12'($urandom());
      run_frame("random_frame", rnd[15:0], 16, 1'b0, 12'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/adc128s_spi_model.md
Name: adc128s_spi_model

Overview:
- Behavioural/synthesizable model of an 8-channel, 12-bit SPI A2D converter (ADC128S-style) for full-chip simulation of the Segway controller.
- Acts as an SPI slave to the controller's A2D master.
- Returns the live load-cell, steering-pot and battery inputs on the addressed channel.
- Result is pipelined: the channel address sent in frame N is returned in frame N+1.

Parameters:
- LFT_CH, 3'd0, channel address returning ld_cell_lft
- RGHT_CH, 3'd4, channel address returning ld_cell_rght
- STEER_CH, 3'd5, channel address returning steerPot
- BATT_CH, 3'd6, channel address returning batt

Ports:
- clk  in  1  system clock; all logic is clocked here, and SCLK is oversampled
- rst_n  in  1  asynchronous active-low reset
- SS_n  in  1  SPI slave select, active low
- SCLK  in  1  SPI serial clock, mode 0, idle low
- MOSI  in  1  SPI data from master
- MISO  out  1  SPI data to master
- ld_cell_lft  in  12  analog value for LFT_CH
- ld_cell_rght  in  12  analog value for RGHT_CH
- steerPot  in  12  analog value for STEER_CH
- batt  in  12  analog value for BATT_CH

Behaviour:
- Input sync: SS_n, SCLK and MOSI are double-flopped into clk. A third SCLK flop provides edge detection.
  - SCLK rise = sync=1 and prev=0.
  - SCLK fall = sync=0 and prev=1.
- Reset values:
  - shift register 16'h0000
  - bit counter 0
  - addressed channel 3'd0
  - synchronizer flops: SS_n=1, SCLK=0
  - MISO = bit 15 of the shift register = 0 (or Z, see Optional Feature)
- Frame start (SS_n sync falling):
  - Load the shift register with {4'b0000, value(chnl)}, where chnl is the currently stored channel.
  - value() is a snapshot taken that clk of the selected input. Unmapped channels (1,2,3,7) return 12'h000.
  - Clear the bit counter.
- SCLK rise while SS_n low: shift left, MOSI into bit 0, increment the bit counter (saturating at 16).
- SCLK fall while SS_n low: no state change. MISO always presents shift_reg[15], so the next MSB appears after the preceding rise.
- Frame format: MSB first, 16 bits.
  - MOSI bits [13:11] = next channel address; all other MOSI bits are ignored.
  - MISO bits [15:12] = 0, bits [11:0] = result.
- Frame end (SS_n sync rising):
  - If exactly 16 rises were counted: chnl <= received[13:11].
  - Otherwise (aborted or over-length frame): chnl is unchanged.
- SS_n high: SCLK and MOSI are ignored.
- The first frame after reset returns the LFT_CH value.
- Input changes mid-frame do not affect the frame in progress.
- Reset mid-frame: all state returns to reset values immediately. The channel returns to 0.
- Latency: the result for the address sent in frame N appears in frame N+1. Back-to-back frames need at least 2 clk of SS_n high.

Optional Feature:
- Macro: ADC_MISO_TRISTATE_EN.
- Defined: MISO = 1'bz while synchronized SS_n is high; shift_reg[15] while low.
- Undefined: MISO is always driven with shift_reg[15]. It reads 0 when idle after reset.

Test Plan:
- After reset, frame sending 16'h2000 (ch4), all inputs distinct -> MISO returns {4'h0, ld_cell_lft}, e.g. ld_cell_lft=12'h300 -> 16'h0300.
- Next frame sending 16'h2800 (ch5), ld_cell_rght=12'h300 -> MISO returns 16'h0300 (ch4); the following frame returns steerPot, e.g. 12'h800 -> 16'h0800.
- Send ch6, then any frame, with batt=12'hFFF -> returns 16'h0FFF; bits [15:12] always 0.
- Address ch3 (unmapped), then any frame -> returns 16'h0000.
- Aborted frame: raise SS_n after 8 SCLK rises with MOSI=ch6 -> channel unchanged; the next full frame returns the previous channel's value.
- Change batt from 12'hA00 to 12'h900 mid-frame -> the frame still returns 16'h0A00. Assert rst_n mid-frame -> the next frame returns ch0. With ADC_MISO_TRISTATE_EN defined, MISO = Z while SS_n is high.
